// File: rtl/difftest_vec_v0_wb_collector_if.sv
// Writeback beat bus into the v0 collector and the merged record bus out to the DPI sink.
interface difftest_vec_v0_wb_collector_if;
  logic        io_in_valid;
  logic        io_in_half;
  logic        io_in_last;
  logic [4:0]  io_in_address;
  logic [63:0] io_in_data;
  logic [7:0]  io_coreid;
  logic        io_out_enable;
  logic        io_out_valid;
  logic [4:0]  io_out_address;
  logic [63:0] io_out_data_0;
  logic [63:0] io_out_data_1;
  logic [7:0]  io_out_coreid;
  logic        io_err_addr;
  logic        io_err_timeout;

  modport master (
    output io_in_valid, io_in_half, io_in_last, io_in_address, io_in_data, io_coreid,
    input  io_out_enable, io_out_valid, io_out_address, io_out_data_0, io_out_data_1,
           io_out_coreid, io_err_addr, io_err_timeout
  );

  modport slave (
    input  io_in_valid, io_in_half, io_in_last, io_in_address, io_in_data, io_coreid,
    output io_out_enable, io_out_valid, io_out_address, io_out_data_0, io_out_data_1,
           io_out_coreid, io_err_addr, io_err_timeout
  );
endinterface

// File: rtl/difftest_vec_v0_wb_collector.sv
// Merges 64-bit half writebacks of v0 into 128-bit records, fills unwritten halves
// from a shadow of the last emitted record, and delays each record by DELAY cycles.
module difftest_vec_v0_wb_collector #(
  parameter int unsigned DELAY   = 1,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  difftest_vec_v0_wb_collector_if.slave  bus
);

  typedef enum logic {IDLE, PARTIAL} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t       state, state_nxt;
  logic         cap_half, cap_half_nxt;
  logic [4:0]   cap_addr, cap_addr_nxt;
  logic [63:0]  cap_data, cap_data_nxt;
  logic [7:0]   idle_cnt, idle_cnt_nxt;
  logic [127:0] shadow;

  logic         emit;
  logic [4:0]   emit_addr;
  logic [127:0] emit_data;
  logic         set_err_addr, set_err_timeout;
  logic         err_addr, err_timeout;
  logic         fresh;

  logic [DELAY-1:0]        dl_valid;
  logic [DELAY-1:0][4:0]   dl_addr;
  logic [DELAY-1:0][127:0] dl_data;
  logic [DELAY-1:0][7:0]   dl_core;

  function automatic logic [127:0] place(input logic [127:0] base, input logic half,
                                         input logic [63:0] d);
    logic [127:0] r;
    r = base;
    if (half) r[127:64] = d;
    else      r[63:0]   = d;
    return r;
  endfunction

  // Beat handling, merge/fill decisions and the PARTIAL idle timeout.
  // An address mismatch in PARTIAL drops the capture and reuses the IDLE path.
  always_comb begin
    state_nxt       = state;
    cap_half_nxt    = cap_half;
    cap_addr_nxt    = cap_addr;
    cap_data_nxt    = cap_data;
    idle_cnt_nxt    = idle_cnt;
    emit            = 1'b0;
    emit_addr       = bus.io_in_address;
    emit_data       = shadow;
    set_err_addr    = 1'b0;
    set_err_timeout = 1'b0;
    fresh           = (state == IDLE) || (bus.io_in_address != cap_addr);

    if (bus.io_in_valid) begin
      idle_cnt_nxt = '0;
      if (state == PARTIAL && bus.io_in_address != cap_addr) set_err_addr = 1'b1;
      if (fresh) begin
        if (bus.io_in_last) begin
          emit      = 1'b1;
          emit_data = place(shadow, bus.io_in_half, bus.io_in_data);
          state_nxt = IDLE;
        end else begin
          cap_half_nxt = bus.io_in_half;
          cap_addr_nxt = bus.io_in_address;
          cap_data_nxt = bus.io_in_data;
          state_nxt    = PARTIAL;
        end
      end else if (bus.io_in_half != cap_half) begin
        emit      = 1'b1;
        emit_data = place(place(shadow, cap_half, cap_data), bus.io_in_half, bus.io_in_data);
        state_nxt = IDLE;
      end else begin
        cap_data_nxt = bus.io_in_data;
        if (bus.io_in_last) begin
          emit      = 1'b1;
          emit_data = place(shadow, bus.io_in_half, bus.io_in_data);
          state_nxt = IDLE;
        end
      end
    end else if (state == PARTIAL) begin
      if (idle_cnt == TO_LAST) begin
        emit            = 1'b1;
        emit_addr       = cap_addr;
        emit_data       = place(shadow, cap_half, cap_data);
        set_err_timeout = 1'b1;
        state_nxt       = IDLE;
      end else begin
        idle_cnt_nxt = idle_cnt + 8'd1;
      end
    end
  end

  // FSM, capture registers, shadow copy and sticky error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cap_half    <= 1'b0;
      cap_addr    <= '0;
      cap_data    <= '0;
      idle_cnt    <= '0;
      shadow      <= '0;
      err_addr    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      cap_half    <= cap_half_nxt;
      cap_addr    <= cap_addr_nxt;
      cap_data    <= cap_data_nxt;
      idle_cnt    <= idle_cnt_nxt;
      if (emit) shadow <= emit_data;
      err_addr    <= err_addr | set_err_addr;
      err_timeout <= err_timeout | set_err_timeout;
    end
  end

  // Fixed-latency delay line; empty stages carry all-zero records.
  always_ff @(posedge clock) begin
    if (reset) begin
      dl_valid <= '0;
      dl_addr  <= '0;
      dl_data  <= '0;
      dl_core  <= '0;
    end else begin
      dl_valid[0] <= emit;
      dl_addr[0]  <= emit ? emit_addr : '0;
      dl_data[0]  <= emit ? emit_data : '0;
      dl_core[0]  <= emit ? bus.io_coreid : '0;
      for (int unsigned i = 1; i < DELAY; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_addr[i]  <= dl_addr[i-1];
        dl_data[i]  <= dl_data[i-1];
        dl_core[i]  <= dl_core[i-1];
      end
    end
  end

  assign bus.io_out_enable  = dl_valid[DELAY-1];
  assign bus.io_out_valid   = dl_valid[DELAY-1];
  assign bus.io_out_address = dl_addr[DELAY-1];
  assign bus.io_out_data_0  = dl_data[DELAY-1][63:0];
  assign bus.io_out_data_1  = dl_data[DELAY-1][127:64];
  assign bus.io_out_coreid  = dl_core[DELAY-1];
  assign bus.io_err_addr    = err_addr;
  assign bus.io_err_timeout = err_timeout;

endmodule

// File: tb/tb_difftest_vec_v0_wb_collector.sv
// Directed and randomized checks of the v0 writeback collector against a record-level model.
module tb_difftest_vec_v0_wb_collector;
  localparam int DLY = 3;
  localparam int TMO = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  difftest_vec_v0_wb_collector_if bus ();

  difftest_vec_v0_wb_collector #(.DELAY(DLY), .TIMEOUT(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          due;
    logic [4:0]  addr;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [7:0]  core;
  } rec_t;

  rec_t        q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  // Reference state: pending half record, last committed v0 halves, sticky flags.
  logic [63:0] sh[2];
  logic        pend;
  logic        p_half;
  logic [4:0]  p_addr;
  logic [63:0] p_data;
  int          quiet;
  logic        m_err_addr, m_err_to;

  task automatic push(input logic [4:0] a, input logic [63:0] h0, input logic [63:0] h1,
                      input logic [7:0] c);
    rec_t r;
    r.due = cyc + DLY; r.addr = a; r.d0 = h0; r.d1 = h1; r.core = c;
    q.push_back(r);
    sh[0] = h0;
    sh[1] = h1;
  endtask

  task automatic check_cycle();
    logic [142:0] obs, exp;
    logic [1:0]   eobs, eexp;
    rec_t         r;
    exp = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      exp = {1'b1, 1'b1, r.addr, r.d0, r.d1, r.core};
    end
    obs = {bus.io_out_enable, bus.io_out_valid, bus.io_out_address, bus.io_out_data_0,
           bus.io_out_data_1, bus.io_out_coreid};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL pulse cyc=%0d obs=%h exp=%h", cyc, obs, exp);
    end
    eobs = {bus.io_err_addr, bus.io_err_timeout};
    eexp = {m_err_addr, m_err_to};
    total++;
    assert (eobs === eexp) else begin
      bad++;
      $error("FAIL errflags cyc=%0d obs=%b exp=%b", cyc, eobs, eexp);
    end
  endtask

  task automatic step(input logic v, input logic h, input logic l, input logic [4:0] a,
                      input logic [63:0] d, input logic [7:0] c, input logic r);
    logic [63:0] w[2];
    bus.io_in_valid   = v;
    bus.io_in_half    = h;
    bus.io_in_last    = l;
    bus.io_in_address = a;
    bus.io_in_data    = d;
    bus.io_coreid     = c;
    reset             = r;
    if (r) begin
      q.delete();
      sh[0] = '0; sh[1] = '0;
      pend = 1'b0; quiet = 0;
      m_err_addr = 1'b0; m_err_to = 1'b0;
    end else if (v) begin
      if (pend && a != p_addr) begin
        m_err_addr = 1'b1;
        pend = 1'b0;
      end
      w = sh;
      if (!pend) begin
        if (l) begin
          w[h] = d;
          push(a, w[0], w[1], c);
        end else begin
          pend = 1'b1; p_half = h; p_addr = a; p_data = d; quiet = 0;
        end
      end else if (h != p_half) begin
        w[p_half] = p_data;
        w[h] = d;
        push(a, w[0], w[1], c);
        pend = 1'b0;
      end else if (!l) begin
        p_data = d;
        quiet = 0;
      end else begin
        w[h] = d;
        push(a, w[0], w[1], c);
        pend = 1'b0;
      end
    end else if (pend) begin
      quiet++;
      if (quiet == TMO) begin
        w = sh;
        w[p_half] = p_data;
        push(p_addr, w[0], w[1], c);
        m_err_to = 1'b1;
        pend = 1'b0;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 8'd0, 1'b0);
  endtask

  initial begin
    logic        rv, rh, rl, rr;
    logic [4:0]  ra;
    logic [63:0] rd;
    logic [7:0]  rc;
    int          pct;

    bus.io_in_valid = 1'b0; bus.io_in_half = 1'b0; bus.io_in_last = 1'b0;
    bus.io_in_address = '0; bus.io_in_data = '0; bus.io_coreid = '0;
    sh[0] = '0; sh[1] = '0; pend = 1'b0; p_half = 1'b0; p_addr = '0; p_data = '0;
    quiet = 0; m_err_addr = 1'b0; m_err_to = 1'b0;

    step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 8'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 8'd0, 1'b1);
    idle(2);

    // merge of two halves; last ignored on the closing half
    step(1'b1, 1'b0, 1'b0, 5'd0, 64'h1111, 8'h05, 1'b0);
    step(1'b1, 1'b1, 1'b0, 5'd0, 64'h2222, 8'h06, 1'b0);
    idle(DLY + 1);

    // single half with shadow fill
    step(1'b1, 1'b1, 1'b1, 5'd0, 64'h3333, 8'h07, 1'b0);
    idle(DLY + 1);

    // timeout, then a beat arriving exactly on the timeout cycle
    step(1'b1, 1'b0, 1'b0, 5'd2, 64'hAAAA, 8'h08, 1'b0);
    idle(TMO + DLY + 2);
    step(1'b1, 1'b1, 1'b0, 5'd9, 64'hBBBB, 8'h09, 1'b0);
    idle(TMO - 1);
    step(1'b1, 1'b1, 1'b0, 5'd9, 64'hCCCC, 8'h0A, 1'b0);
    idle(TMO + DLY + 2);

    // address mismatch discards the capture
    step(1'b1, 1'b0, 1'b0, 5'd0, 64'hDEAD, 8'h0B, 1'b0);
    step(1'b1, 1'b1, 1'b1, 5'd3, 64'hBEEF, 8'h0C, 1'b0);
    idle(DLY + 1);

    // streaming back-to-back records
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b1, 5'd1, 64'(i), 8'(i), 1'b0);
    idle(DLY + 1);

    // reset with a capture pending and records in flight
    step(1'b1, 1'b0, 1'b1, 5'd4, 64'h4444, 8'h11, 1'b0);
    step(1'b1, 1'b1, 1'b1, 5'd4, 64'h5555, 8'h12, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd6, 64'h6666, 8'h13, 1'b0);
    step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 8'd0, 1'b1);
    idle(TMO + DLY + 2);
    step(1'b1, 1'b1, 1'b1, 5'd5, 64'h7777, 8'h14, 1'b0);
    idle(DLY + 1);

    // randomized traffic with alternating dense and sparse phases
    for (int n = 0; n < 800; n++) begin
      pct = ((n / 100) % 2 == 1) ? 15 : 70;
      rv  = ($urandom_range(99) < pct);
      rh  = 1'($urandom_range(1));
      rl  = ($urandom_range(2) == 0);
      ra  = ($urandom_range(9) == 0) ? 5'($urandom_range(31)) : 5'd4;
      rd  = {$urandom, $urandom};
      rc  = 8'($urandom_range(255));
      rr  = ($urandom_range(249) == 0);
      step(rv, rh, rl, ra, rd, rc, rr);
    end
    idle(TMO + DLY + 2);

    total++;
    assert (q.size() == 0) else begin
      bad++;
      $error("FAIL drain pending=%0d required=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/difftest_vec_v0_wb_collector.md
Name: difftest_vec_v0_wb_collector

Overview:
- Sits directly upstream of the difftest vector-V0 writeback DPI sink.
- Collects 64-bit half-register writebacks of the 128-bit v0 register from the vector backend and merges them into one complete record.
- Fills any half that was not written from a shadow copy of the last committed v0.
- Passes each record through a fixed-latency delay line and presents it as a one-cycle enable/valid pulse with address, both data halves and core ID, matching the sink's inputs.

Parameters:
DELAY, 1, output pipeline depth in cycles; legal range 1..8.
TIMEOUT, 16, idle cycles in PARTIAL before a forced emit; legal range 2..255.

Ports:
clock  input  1  core clock
reset  input  1  synchronous, active-high reset
io_in_valid  input  1  writeback beat valid
io_in_half  input  1  0 = bits 63:0, 1 = bits 127:64
io_in_last  input  1  beat closes the record
io_in_address  input  5  destination vreg index
io_in_data  input  64  half data
io_coreid  input  8  core ID, sampled with the completing beat
io_out_enable  output  1  sink enable pulse
io_out_valid  output  1  equal to io_out_enable
io_out_address  output  5  record address
io_out_data_0  output  64  bits 63:0
io_out_data_1  output  64  bits 127:64
io_out_coreid  output  8  record core ID
io_err_addr  output  1  sticky: address changed mid-record
io_err_timeout  output  1  sticky: record forced out by timeout

Behaviour:
- Reset (synchronous, active-high, any cycle including mid-record):
  - FSM goes to IDLE; capture registers, shadow (128 b) and all delay stages clear to 0.
  - Every output is 0 from the cycle after reset is sampled; sticky errors clear.
- FSM states: IDLE, PARTIAL. Capture registers: cap_half, cap_addr, cap_data.
- IDLE, valid beat:
  - last=1: emit {this half, other half from shadow}.
  - last=0: capture the beat, go to PARTIAL.
- PARTIAL, valid beat, same address:
  - Other half: merge with the capture, emit, go to IDLE (io_in_last ignored).
  - Same half, last=0: overwrite cap_data (later write wins), stay in PARTIAL.
  - Same half, last=1: overwrite, emit with shadow fill, go to IDLE.
- PARTIAL, valid beat, different address:
  - Set io_err_addr; discard the capture; process the beat exactly as from IDLE in the same cycle.
- Timeout:
  - Idle counter resets on entry to PARTIAL and on every beat; it increments each PARTIAL cycle without a valid beat.
  - In the cycle TIMEOUT cycles after the last beat, with still no beat: emit the capture with shadow fill, set io_err_timeout, go to IDLE.
  - A valid beat in that same cycle takes priority over the timeout.
- Emit: at most one per cycle.
  - Record address = beat or capture address; coreid = io_coreid in the emit cycle.
  - Shadow <= emitted 128-bit data at the same clock edge; the next beat sees the updated shadow.
- Delay line:
  - A record emitted in cycle T appears on the outputs in cycle T+DELAY for exactly one cycle.
  - Outputs hold 0 in cycles with no record.
  - Back-to-back emits produce back-to-back output pulses.
  - No backpressure; no record is ever dropped except a capture discarded on address mismatch.
- io_in_* are ignored when io_in_valid=0.

Test Plan:
1. Merge: DELAY=1, beats half0 0x1111 (last=0) at T, half1 0x2222 at T+1 -> output pulse at T+2 with data_0=0x1111, data_1=0x2222, addr 0; no errors.
2. Shadow fill: after test 1, single beat half1 0x3333 last=1 at T -> at T+1 data_0=0x1111, data_1=0x3333.
3. Timeout: TIMEOUT=4, half0 0xAAAA last=0 at T, then idle -> emit at T+4, output at T+5 with data_1 taken from shadow; io_err_timeout=1 and stays 1.
4. Address mismatch: half0 addr 0 last=0, then half1 addr 3 last=1 next cycle -> io_err_addr=1; single output addr 3 with data_0 from shadow; old capture never output.
5. Streaming: DELAY=3, last=1 half0 beats with values 1..8 on consecutive cycles -> 8 consecutive output pulses starting 3 cycles after the first beat, data_0=1..8 in order.
6. Reset mid-operation: capture in PARTIAL and records in the delay line, assert reset for one cycle -> all outputs 0 from the next cycle; no pulse ever emerges; the next merge uses a zero shadow.
